axis_cpu_loader: RTL
====================

AXIS_CPU_LOADER -- requirements
Module: axis_cpu_loader

Interface
REQ-001 Parameter CODE_ADDR_WIDTH, default 10: instruction-memory address width of the target CPU; the legal range is 1..16.
REQ-002 Parameter RESP_TIMEOUT, default 1024: the number of cycles WAIT_RESP waits before an error; used only when LOADER_TIMEOUT_EN is defined.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 prog_TDATA  in  32  program word.
REQ-007 prog_TVALID  in  1  program word valid.
REQ-008 prog_TREADY  out  1  program word accepted.
REQ-009 prog_TLAST  in  1  last word of the program image.
REQ-010 start_addr  in  CODE_ADDR_WIDTH  load base address; sampled on the IDLE->HOLD transition.
REQ-011 cmd_TDATA  out  32  command word to the CPU programming port.
REQ-012 cmd_TVALID  out  1  command valid; the CPU programming port has no backpressure.
REQ-013 resp_TDATA  in  32  response word from the CPU command output.
REQ-014 resp_TVALID  in  1  response valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a load finishes, with or without error.
REQ-017 err  out  1  sticky error flag; cleared on the IDLE->HOLD transition.

Function
REQ-018 Command word format is {op[7:0], field[23:0]}: HOLD=0x01, WADDR=0x03, RELEASE=0x04.
REQ-019 The CPU programming port is raw write-only, so every program word SHALL be preceded by a WADDR header: data words are sent in pairs, never raw runs.
REQ-020 State machine states: IDLE, HOLD, HDR, DATA, DRAIN, RELEASE, WAIT_RESP.
REQ-021 IDLE: when prog_TVALID=1, go to HOLD; capture start_addr into addr and set count=0; the word is not consumed.
REQ-022 HOLD: drive cmd=0x01000000 with TVALID for one cycle; go to HDR.
REQ-023 HDR: drive cmd={0x03, 24'(addr)} only when prog_TVALID=1; with prog_TVALID=0, cmd_TVALID=0 and the state stays HDR; after the header, go to DATA.
REQ-024 DATA: prog_TREADY=1; on handshake, drive cmd_TDATA=prog_TDATA the same cycle; wrapping addr+1 mod 2^CODE_ADDR_WIDTH; count+1.
REQ-025 DATA: prog_TREADY is high for exactly one cycle per pair, so the peak program rate is one word per two cycles.
REQ-026 DATA: on the accepted word, TLAST=1 goes to RELEASE; otherwise go to HDR.
REQ-027 DATA overflow: if count reaches 2^CODE_ADDR_WIDTH after the increment and TLAST=0, set err and go to DRAIN.
REQ-028 DRAIN: prog_TREADY=1 and cmd_TVALID=0; discard words until TLAST; then go to RELEASE.
REQ-029 RELEASE: drive cmd={0x04, 8'h0, count[15:0]} for one cycle; go to WAIT_RESP.
REQ-030 WAIT_RESP: on the first resp_TVALID, compare the response with {0x04, 8'h0, count[15:0]}; a mismatch sets err.
REQ-031 WAIT_RESP: on that response, pulse done and go to IDLE.
REQ-032 resp_TVALID outside WAIT_RESP SHALL be ignored.
REQ-033 cmd_TDATA, cmd_TVALID, prog_TREADY and busy SHALL be driven combinationally from state and registers; there are no internal buffers.
REQ-034 prog_TREADY=0 in IDLE, HOLD, HDR, RELEASE and WAIT_RESP.
REQ-035 A single-word image (TLAST on the first word) SHALL produce exactly HOLD, WADDR, data, RELEASE(count=1).
REQ-036 cmd_TDATA=0 whenever cmd_TVALID=0.

Reset
REQ-037 On rst=0, asynchronously: state=IDLE, addr=0, count=0, and all outputs 0.
REQ-038 A reset mid-load SHALL abandon the load with no RELEASE emitted; the CPU remains held until the next load.
REQ-039 After reset deassertion, the first transition out of IDLE SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-040 Macro LOADER_TIMEOUT_EN defined: a counter runs in WAIT_RESP, clearing on entry.
REQ-041 LOADER_TIMEOUT_EN defined: after RESP_TIMEOUT cycles with no resp_TVALID, set err, pulse done and go to IDLE.
REQ-042 LOADER_TIMEOUT_EN undefined: WAIT_RESP waits indefinitely, and the counter logic is absent.

Verification
REQ-043 3-word image, start_addr=5, prog_TVALID always 1 -> cmd sequence 01000000, 03000005, w0, 03000006, w1, 03000007, w2, 04000003; resp 04000003 -> done pulse, err=0.
REQ-044 prog_TVALID toggled 1-0-1 in HDR -> no cmd_TVALID while invalid; cmd order unchanged; no words lost or duplicated.
REQ-045 CODE_ADDR_WIDTH=2, start_addr=3, 6-word image -> headers 03000003, 03000000, 03000001, 03000002; 2 words drained; err=1; RELEASE 04000004.
REQ-046 Response 04000002 to RELEASE 04000003 -> err=1, done pulse; next load start clears err.
REQ-047 rst asserted during DATA -> all outputs 0 immediately; a new 1-word load then completes normally.
REQ-048 LOADER_TIMEOUT_EN defined, RESP_TIMEOUT=8, no response -> err=1 and done 8 cycles after RELEASE; undefined -> busy stays 1.

Source files
------------

// File: rtl/axis_cpu_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | axis_cpu_loader: streams an AXIS program image into a CPU programming port |
// | as HOLD / (WADDR, data)* / RELEASE commands, then checks the CPU response. |
// | Optional macro LOADER_TIMEOUT_EN bounds the wait for that response.        |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module axis_cpu_loader #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int RESP_TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                prog_TDATA,
  input  logic                       prog_TVALID,
  output logic                       prog_TREADY,
  input  logic                       prog_TLAST,
  input  logic [CODE_ADDR_WIDTH-1:0] start_addr,
  output logic [31:0]                cmd_TDATA,
  output logic                       cmd_TVALID,
  input  logic [31:0]                resp_TDATA,
  input  logic                       resp_TVALID,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int         c_cnt_w      = CODE_ADDR_WIDTH + 1;
  localparam logic [7:0] c_op_hold    = 8'h01;
  localparam logic [7:0] c_op_waddr   = 8'h03;
  localparam logic [7:0] c_op_release = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_HDR, S_DATA, S_DRAIN, S_RELEASE, S_WAIT_RESP
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [CODE_ADDR_WIDTH-1:0] r_addr;
  logic [c_cnt_w-1:0]         r_count, w_count_inc;
  logic                       r_err, r_done, r_armed;
  logic                       w_load, w_accept, w_finish, w_set_err, w_timeout;
  logic [31:0]                w_release;

  assign w_count_inc = r_count + 1'b1;
  assign w_release   = {c_op_release, 8'h00, 16'(r_count)};
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

`ifdef LOADER_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(RESP_TIMEOUT + 1);
  logic [c_tmo_w-1:0] r_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_tmo <= '0;
    else if (r_state == S_RELEASE)   r_tmo <= '0;
    else if (r_state == S_WAIT_RESP) r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT_RESP) && (r_tmo == c_tmo_w'(RESP_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_TVALID  = 1'b0;
    cmd_TDATA   = 32'h0;
    prog_TREADY = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_armed holds off the first load until one edge after reset release
        if (r_armed && prog_TVALID) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        cmd_TVALID  = 1'b1;
        cmd_TDATA   = {c_op_hold, 24'h0};
        w_state_nxt = S_HDR;
      end
      S_HDR: begin
        if (prog_TVALID) begin
          cmd_TVALID  = 1'b1;
          cmd_TDATA   = {c_op_waddr, 24'(r_addr)};
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        prog_TREADY = 1'b1;
        if (prog_TVALID) begin
          w_accept   = 1'b1;
          cmd_TVALID = 1'b1;
          cmd_TDATA  = prog_TDATA;
          if (prog_TLAST) begin
            w_state_nxt = S_RELEASE;
          end else if (w_count_inc[c_cnt_w-1]) begin
            // count hit 2^CODE_ADDR_WIDTH: the image no longer fits
            w_set_err   = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_HDR;
          end
        end
      end
      S_DRAIN: begin
        prog_TREADY = 1'b1;
        if (prog_TVALID && prog_TLAST) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        cmd_TVALID  = 1'b1;
        cmd_TDATA   = w_release;
        w_state_nxt = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (resp_TVALID) begin
          w_finish    = 1'b1;
          w_set_err   = (resp_TDATA != w_release);
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_finish    = 1'b1;
          w_set_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= w_finish;
      if (w_load) begin
        r_addr  <= start_addr;
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= w_count_inc;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
